mem_responder: RTL and testbench

- Data-memory responder at the far end of the control unit's memory request interface.
- Accepts single read/write requests with a size code (WORD/HALF/BYTE) and models a fixed access latency. Returns size-aligned, zero-extended read data with a one-cycle Done pulse.
- Contains a small word array and flags misaligned or out-of-range accesses.
- Sits between the datapath address mux (PC / ALUOut select) plus MDR and the rest of the system.

---
 rtl/mem_pkg.sv | 33 +++
 rtl/mem_lane_unit.sv | 40 ++++
 rtl/mem_responder.sv | 143 ++++++++++++++
 tb/tb_mem_responder.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types for the data-memory request interface: size codes, responder
// states and a byte-lane mask helper used by the lane unit.
package mem_pkg;

  // Size codes match the control unit's load/store size field; 2'b11 is reserved.
  typedef enum logic [1:0] {
    MEM_WORD = 2'b00,
    MEM_HALF = 2'b01,
    MEM_BYTE = 2'b10
  } mem_size_t;

  typedef enum logic [1:0] {
    MR_IDLE = 2'b00,
    MR_WAIT = 2'b01,
    MR_RESP = 2'b10
  } mr_state_t;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = 4;

  // Bit mask covering the lanes touched by an access of the given size at the given lane.
  function automatic logic [31:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
    logic [31:0] base;
    case (size)
      MEM_WORD: base = 32'hFFFF_FFFF;
      MEM_HALF: base = 32'h0000_FFFF;
      MEM_BYTE: base = 32'h0000_00FF;
      default:  base = 32'h0000_0000;
    endcase
    return base << {lane, 3'b000};
  endfunction

endpackage

// File: rtl/mem_lane_unit.sv
// Combinational byte-lane steering: merges store data into the old word,
// extracts and zero-extends load data, and flags misaligned accesses.
module mem_lane_unit
  import mem_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  output logic [31:0] store_word,
  output logic [31:0] load_word,
  output logic        misalign
);

  logic [31:0] mask_s;
  logic [4:0]  shamt_s;
  logic [31:0] wdata_shifted_s;

  assign shamt_s         = {lane, 3'b000};
  assign mask_s          = lane_mask(size, lane);
  assign wdata_shifted_s = wdata << shamt_s;

  // Read-modify-write merge and right-justified extraction of the selected lanes.
  always_comb begin
    store_word = (old_word & ~mask_s) | (wdata_shifted_s & mask_s);
    load_word  = (old_word & mask_s) >> shamt_s;
  end

  // Alignment rule per size; the reserved code is reported separately by the caller.
  always_comb begin
    misalign = 1'b0;
    case (size)
      MEM_WORD: misalign = (lane != 2'b00);
      MEM_HALF: misalign = lane[0];
      MEM_BYTE: misalign = 1'b0;
      default:  misalign = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// Data-memory responder: accepts one request at a time, waits a fixed number
// of edges, then performs the access and pulses Done with registered RData/Err.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned LATENCY = 3
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req,
  input  logic        ReqWrite,
  input  logic [1:0]  ReqSize,
  input  logic [31:0] Addr,
  input  logic [31:0] WData,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] RData,
  output logic        Err
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  mr_state_t          state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               write_r;
  logic [1:0]         size_r;
  logic [31:0]        addr_r;
  logic [31:0]        wdata_r;
  logic               busy_r;
  logic               done_r;
  logic [31:0]        rdata_r;
  logic               err_r;
  logic [WORD_W-1:0]  mem_r [DEPTH];

  logic [IDX_W-1:0]   idx_s;
  logic               oor_s;
  logic               size_bad_s;
  logic               misalign_s;
  logic               err_s;
  logic               access_s;
  logic               mem_we_s;
  logic [31:0]        old_word_s;
  logic [31:0]        store_word_s;
  logic [31:0]        load_word_s;

  assign idx_s      = addr_r[IDX_W+1:2];
  assign oor_s      = ({2'b00, addr_r[31:2]} >= 32'(DEPTH));
  assign size_bad_s = (size_r == 2'b11);
  assign err_s      = oor_s | misalign_s | size_bad_s;
  // The access happens on the edge that leaves WAIT with an expired counter.
  assign access_s   = (state_r == MR_WAIT) && (cnt_r == {CNT_W{1'b0}});
  assign mem_we_s   = access_s && write_r && !err_s;

  // Fetch the addressed word; out-of-range indices never touch the array.
  always_comb begin
    old_word_s = 32'h0000_0000;
    if (oor_s) begin
      old_word_s = 32'h0000_0000;
    end else begin
      old_word_s = mem_r[idx_s];
    end
  end

  mem_lane_unit u_lane (
    .old_word   (old_word_s),
    .wdata      (wdata_r),
    .lane       (addr_r[1:0]),
    .size       (size_r),
    .store_word (store_word_s),
    .load_word  (load_word_s),
    .misalign   (misalign_s)
  );

  // Word array: cleared by reset, written only on a successful store access edge.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_r[i] <= 32'h0000_0000;
      end
    end else if (mem_we_s) begin
      mem_r[idx_s] <= store_word_s;
    end
  end

  // Request FSM with latency counter, captured request fields and registered outputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_r <= MR_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      write_r <= 1'b0;
      size_r  <= 2'b00;
      addr_r  <= 32'h0000_0000;
      wdata_r <= 32'h0000_0000;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      rdata_r <= 32'h0000_0000;
      err_r   <= 1'b0;
    end else begin
      case (state_r)
        MR_IDLE: begin
          done_r <= 1'b0;
          if (Req) begin
            write_r <= ReqWrite;
            size_r  <= ReqSize;
            addr_r  <= Addr;
            wdata_r <= WData;
            cnt_r   <= CNT_W'(LATENCY - 1);
            busy_r  <= 1'b1;
            state_r <= MR_WAIT;
          end
        end
        MR_WAIT: begin
          if (cnt_r == {CNT_W{1'b0}}) begin
            state_r <= MR_RESP;
            done_r  <= 1'b1;
            err_r   <= err_s;
            // Stores and failed accesses report zero data.
            rdata_r <= (err_s || write_r) ? 32'h0000_0000 : load_word_s;
          end else begin
            cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        MR_RESP: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= MR_IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= MR_IDLE;
        end
      endcase
    end
  end

  assign Busy  = busy_r;
  assign Done  = done_r;
  assign RData = rdata_r;
  assign Err   = err_r;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: a LATENCY=3 instance carries the main
// sequence, a LATENCY=1 instance checks the short-latency timing.
module tb_mem_responder;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_a, req_b, req_write;
  logic [1:0]  req_size;
  logic [31:0] addr, wdata;
  logic        busy_a, done_a, err_a, busy_b, done_b, err_b;
  logic [31:0] rdata_a, rdata_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int prev_done_cyc = -1;
  logic [32:0] exp_q_a[$];
  logic [32:0] exp_q_b[$];
  logic [32:0] e_a, e_b;

  always #5 clk = ~clk;

  // Cycle counter used for Done-to-Done spacing.
  always @(posedge clk) cyc <= cyc + 1;

  mem_responder #(.DEPTH(64), .LATENCY(3)) dut_a (
    .Clk(clk), .Reset(reset), .Req(req_a), .ReqWrite(req_write), .ReqSize(req_size),
    .Addr(addr), .WData(wdata), .Busy(busy_a), .Done(done_a), .RData(rdata_a), .Err(err_a)
  );

  mem_responder #(.DEPTH(64), .LATENCY(1)) dut_b (
    .Clk(clk), .Reset(reset), .Req(req_b), .ReqWrite(req_write), .ReqSize(req_size),
    .Addr(addr), .WData(wdata), .Busy(busy_b), .Done(done_b), .RData(rdata_b), .Err(err_b)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Scoreboard for instance A: every Done pops one expected response.
  always @(negedge clk) begin
    if (done_a) begin
      if (exp_q_a.size() == 0) begin
        chk("a_unexpected_done", 32'(exp_q_a.size()), 32'd1);
      end else begin
        e_a = exp_q_a.pop_front();
        chk("a_rdata", rdata_a, e_a[31:0]);
        chk("a_err", {31'b0, err_a}, {31'b0, e_a[32]});
      end
    end
  end

  // Scoreboard for instance B.
  always @(negedge clk) begin
    if (done_b) begin
      if (exp_q_b.size() == 0) begin
        chk("b_unexpected_done", 32'(exp_q_b.size()), 32'd1);
      end else begin
        e_b = exp_q_b.pop_front();
        chk("b_rdata", rdata_b, e_b[31:0]);
        chk("b_err", {31'b0, err_b}, {31'b0, e_b[32]});
      end
    end
  end

  // Issue one request right after a negedge (accepted on the next posedge),
  // follow it to Done, check latency/Busy length, and stop in the IDLE cycle after Done.
  task automatic do_req(input bit inst, input bit wr, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input bit exp_err,
                        input bit poke, input bit b2b);
    int n = 0;
    int nbusy = 0;
    bit seen = 1'b0;
    int lat = inst ? 1 : 3;
    logic bsy, dn;
    req_write = wr; req_size = sz; addr = a; wdata = wd;
    if (inst) begin
      exp_q_b.push_back({exp_err, exp_rd});
      req_b = 1'b1;
    end else begin
      exp_q_a.push_back({exp_err, exp_rd});
      req_a = 1'b1;
    end
    @(posedge clk);
    #1;
    if (poke) begin
      // Hold Req high with a different address through WAIT and RESP.
      addr = 32'h0000_0044; wdata = 32'h5555_5555; req_write = ~wr;
    end else begin
      req_a = 1'b0; req_b = 1'b0;
    end
    while (n < 40 && !seen) begin
      @(negedge clk);
      n++;
      bsy = inst ? busy_b : busy_a;
      dn  = inst ? done_b : done_a;
      if (bsy) nbusy++;
      if (dn) seen = 1'b1;
    end
    req_a = 1'b0; req_b = 1'b0;
    chk("done_seen", 32'(seen), 32'd1);
    chk("latency", 32'(n), 32'(lat + 1));
    chk("busy_cycles", 32'(nbusy), 32'(lat + 1));
    if (b2b && prev_done_cyc >= 0) chk("b2b_gap", 32'(cyc - prev_done_cyc - 1), 32'(lat + 1));
    if (!inst) prev_done_cyc = cyc;
    @(negedge clk);
    bsy = inst ? busy_b : busy_a;
    dn  = inst ? done_b : done_a;
    chk("done_one_cycle", {31'b0, dn}, 32'd0);
    chk("busy_after", {31'b0, bsy}, 32'd0);
  endtask

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; req_a = 1'b0; req_b = 1'b0; req_write = 1'b0;
    req_size = 2'b00; addr = 32'h0; wdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'b0, busy_a}, 32'd0);
    chk("rst_done", {31'b0, done_a}, 32'd0);
    chk("rst_rdata", rdata_a, 32'h0);
    chk("rst_err", {31'b0, err_a}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Word store/load, byte merge, lane extraction.
    do_req(0, 1, MEM_WORD, 32'h10, 32'hDEADBEEF, 32'h0, 0, 0, 0);
    do_req(0, 0, MEM_WORD, 32'h10, 32'h0, 32'hDEADBEEF, 0, 0, 1);
    do_req(0, 1, MEM_BYTE, 32'h11, 32'h000000AA, 32'h0, 0, 0, 1);
    do_req(0, 0, MEM_WORD, 32'h10, 32'h0, 32'hDEADAAEF, 0, 0, 1);
    do_req(0, 0, MEM_BYTE, 32'h13, 32'h0, 32'h000000DE, 0, 0, 1);
    do_req(0, 0, MEM_HALF, 32'h12, 32'h0, 32'h0000DEAD, 0, 0, 1);
    // Error cases; memory must stay intact.
    do_req(0, 0, MEM_HALF, 32'h11, 32'h0, 32'h0, 1, 0, 0);
    do_req(0, 0, MEM_WORD, 32'h10, 32'h0, 32'hDEADAAEF, 0, 0, 0);
    do_req(0, 1, MEM_WORD, 32'h102, 32'hFFFFFFFF, 32'h0, 1, 0, 0);
    do_req(0, 0, MEM_WORD, 32'h100, 32'h0, 32'h0, 1, 0, 0);
    do_req(0, 1, 2'b11, 32'h10, 32'h11111111, 32'h0, 1, 0, 0);
    // Req held high during WAIT/RESP must not produce a second access.
    do_req(0, 0, MEM_WORD, 32'h10, 32'h0, 32'hDEADAAEF, 0, 1, 0);
    do_req(0, 1, MEM_HALF, 32'h16, 32'hFFFF1234, 32'h0, 0, 0, 0);
    do_req(0, 0, MEM_WORD, 32'h14, 32'h0, 32'h12340000, 0, 0, 0);
    do_req(0, 0, MEM_BYTE, 32'h16, 32'h0, 32'h00000034, 0, 0, 0);

    // Reset during WAIT with cnt=1 aborts the store.
    req_write = 1'b1; req_size = MEM_WORD; addr = 32'h20; wdata = 32'h12345678; req_a = 1'b1;
    @(posedge clk);
    #1 req_a = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_busy", {31'b0, busy_a}, 32'd0);
    chk("midrst_done", {31'b0, done_a}, 32'd0);
    chk("midrst_rdata", rdata_a, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_req(0, 0, MEM_WORD, 32'h20, 32'h0, 32'h0, 0, 0, 0);
    do_req(0, 0, MEM_WORD, 32'h10, 32'h0, 32'h0, 0, 0, 0);

    // LATENCY=1 instance.
    do_req(1, 1, MEM_WORD, 32'h0, 32'hCAFEF00D, 32'h0, 0, 0, 0);
    do_req(1, 0, MEM_WORD, 32'h0, 32'h0, 32'hCAFEF00D, 0, 0, 0);
    do_req(1, 1, MEM_BYTE, 32'h3, 32'h00000077, 32'h0, 0, 0, 0);
    do_req(1, 0, MEM_WORD, 32'h0, 32'h0, 32'h77FEF00D, 0, 0, 0);

    repeat (10) @(negedge clk);
    chk("a_queue_empty", 32'(exp_q_a.size()), 32'd0);
    chk("b_queue_empty", 32'(exp_q_b.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
